// File: rtl/rx_session_ctrl_if.sv
// Control/status bundle between host logic and rx_session_ctrl.
// Master side drives requests and transport events; slave side is the controller.
interface rx_session_ctrl_if #(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned TO_W  = 32
);
    logic             i_start;
    logic             i_abort;
    logic [CNT_W-1:0] i_expect_words;
    logic [TO_W-1:0]  i_timeout_cycles;
    logic             i_hsked;
    logic             i_tlast;
    logic             i_rx_done;
    logic             o_rx_rcving;
    logic             o_busy;
    logic             o_done;
    logic [1:0]       o_status;
    logic [CNT_W-1:0] o_word_cnt;

    modport master (
        output i_start, i_abort, i_expect_words, i_timeout_cycles,
        output i_hsked, i_tlast, i_rx_done,
        input  o_rx_rcving, o_busy, o_done, o_status, o_word_cnt
    );

    modport slave (
        input  i_start, i_abort, i_expect_words, i_timeout_cycles,
        input  i_hsked, i_tlast, i_rx_done,
        output o_rx_rcving, o_busy, o_done, o_status, o_word_cnt
    );
endinterface

// File: rtl/rx_session_ctrl.sv
// Receive-session sequencer: opens the transport, counts data beats, closes on done/abort/watchdog.
// Define RX_WATCHDOG_EN to build the idle-gap watchdog (status 10).
module rx_session_ctrl #(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned TO_W  = 32
) (
    input logic               s_axis_aclk,
    input logic               s_axis_aresetn,
    rx_session_ctrl_if.slave  bus
);
    localparam logic [1:0] StatOk      = 2'b00;
    localparam logic [1:0] StatCount   = 2'b01;
    localparam logic [1:0] StatTimeout = 2'b10;
    localparam logic [1:0] StatAbort   = 2'b11;

    typedef enum logic [1:0] {StIdle, StRecv, StFinish} state_e;

    state_e           r_state, w_state_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d, w_cnt_inc;
    logic [CNT_W-1:0] r_expect, w_expect_d;
    logic [1:0]       r_status, w_status_d;
    logic             r_rcving, r_busy, r_done;
    logic             w_beat, w_wd_expire;

    // Terminator beat never counts; count saturates at all-ones.
    assign w_beat    = bus.i_hsked & ~bus.i_tlast;
    assign w_cnt_inc = (w_beat && (r_cnt != '1)) ? r_cnt + CNT_W'(1) : r_cnt;

`ifdef RX_WATCHDOG_EN
    logic [TO_W-1:0] r_timeout, w_timeout_d, r_wd, w_wd_d;

    // Expires on the idle cycle that makes the gap reach the latched limit.
    assign w_wd_expire = (r_state == StRecv) && !bus.i_hsked && (r_timeout != '0) &&
                         ((r_wd + TO_W'(1)) == r_timeout);

    always_comb begin
        w_wd_d      = r_wd;
        w_timeout_d = r_timeout;
        if (r_state == StIdle) begin
            if (bus.i_start) begin
                w_wd_d      = '0;
                w_timeout_d = bus.i_timeout_cycles;
            end
        end else if (r_state == StRecv) begin
            if (bus.i_hsked)             w_wd_d = '0;
            else if (r_timeout != '0)    w_wd_d = r_wd + TO_W'(1);
        end
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            r_wd      <= '0;
            r_timeout <= '0;
        end else begin
            r_wd      <= w_wd_d;
            r_timeout <= w_timeout_d;
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^bus.i_timeout_cycles;
    assign w_wd_expire      = 1'b0;
`endif

    always_comb begin
        w_state_d  = r_state;
        w_cnt_d    = r_cnt;
        w_expect_d = r_expect;
        w_status_d = r_status;
        unique case (r_state)
            StIdle: begin
                if (bus.i_start) begin
                    w_state_d  = StRecv;
                    w_cnt_d    = '0;
                    w_expect_d = bus.i_expect_words;
                    w_status_d = StatOk;
                end
            end
            StRecv: begin
                w_cnt_d = w_cnt_inc;
                if (bus.i_abort) begin
                    w_state_d  = StFinish;
                    w_status_d = StatAbort;
                end else if (bus.i_rx_done) begin
                    w_state_d  = StFinish;
                    w_status_d = ((r_expect == '0) || (w_cnt_inc == r_expect)) ? StatOk
                                                                                 : StatCount;
                end else if (w_wd_expire) begin
                    w_state_d  = StFinish;
                    w_status_d = StatTimeout;
                end
            end
            StFinish: w_state_d = StIdle;
            default:  w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_expect <= '0;
            r_status <= StatOk;
            r_rcving <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_cnt    <= w_cnt_d;
            r_expect <= w_expect_d;
            r_status <= w_status_d;
            r_rcving <= (w_state_d == StRecv);
            r_busy   <= (w_state_d != StIdle);
            r_done   <= (w_state_d == StFinish);
        end
    end

    assign bus.o_rx_rcving = r_rcving;
    assign bus.o_busy      = r_busy;
    assign bus.o_done      = r_done;
    assign bus.o_status    = r_status;
    assign bus.o_word_cnt  = r_cnt;
endmodule
